// File: rtl/cva6_trace_buffer.sv
// cva6_trace_buffer
// Merges the per-commit-port trace records of the CVA6 core into one
// ready/valid stream toward the FireSim trace bridge. Records are kept in a
// first-word fall-through circular FIFO in ascending commit-port order, so
// retirement order survives downstream backpressure. When a cycle's records
// do not all fit, none of them are stored. They are counted as dropped, and a
// sticky overflow flag is raised, so the trace tool sees a gap instead of
// records that are silently out of order.
module cva6_trace_buffer #(
    parameter  int NR_PORTS = 2,
    parameter  int REC_W    = 128,
    parameter  int DEPTH    = 16,
    parameter  int CNT_W    = 16,
    localparam int PORT_W   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
    localparam int OCC_W    = $clog2(DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [NR_PORTS-1:0]       in_valid_i,
    input  logic [NR_PORTS*REC_W-1:0] in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [REC_W-1:0]          out_data_o,
    output logic [PORT_W-1:0]         out_port_o,
    output logic [OCC_W-1:0]          count_o,
    output logic [CNT_W-1:0]          drop_cnt_o,
    output logic                      overflow_o,
    input  logic                      clear_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + OCC_W;

    // Record storage. It has no reset: the head outputs come from storage
    // only and are meaningful only while out_valid_o is high.
    logic [REC_W-1:0]  r_mem_data [DEPTH];
    logic [PORT_W-1:0] r_mem_port [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;

    logic [OCC_W-1:0] w_k;
    logic [PTR_W-1:0] w_off [NR_PORTS];
    logic             w_deq;
    logic [OCC_W-1:0] w_space;
    logic             w_accept;
    logic             w_drop;
    logic [SUM_W-1:0] w_drop_sum;
    logic [CNT_W-1:0] w_drop_sat;
    logic [OCC_W-1:0] w_count_next;

    // Count this cycle's valid records. Each valid port gets the write slot
    // offset equal to the number of valid ports below it, which packs the
    // records densely in ascending port order.
    always_comb begin
        w_k = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            w_off[i] = w_k[PTR_W-1:0];
            if (enable_i && in_valid_i[i]) begin
                w_k = w_k + OCC_W'(1);
            end
        end
    end

    // A pop in this cycle frees a slot for this cycle's push. The batch is
    // either stored whole or dropped whole. The drop counter saturates.
    always_comb begin
        w_deq        = (r_count != '0) && out_ready_i;
        w_space      = OCC_W'(DEPTH) - r_count + OCC_W'(w_deq);
        w_accept     = (w_k != '0) && (w_k <= w_space);
        w_drop       = (w_k > w_space);
        w_drop_sum   = SUM_W'(r_drop_cnt) + SUM_W'(w_k);
        w_drop_sat   = (w_drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                            : w_drop_sum[CNT_W-1:0];
        w_count_next = r_count + (w_accept ? w_k : '0) - OCC_W'(w_deq);
    end

    // Pointers, occupancy and drop bookkeeping. A clear takes priority over
    // a drop in the same cycle, and that cycle's drops are not counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + w_k[PTR_W-1:0];
            end
            r_count <= w_count_next;
            if (clear_i) begin
                r_drop_cnt <= '0;
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_drop_cnt <= w_drop_sat;
                r_overflow <= 1'b1;
            end
        end
    end

    // Store each accepted record with its source port. The slots are distinct
    // because the offsets are distinct and never reach DEPTH.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_PORTS; i++) begin
            if (w_accept && in_valid_i[i]) begin
                r_mem_data[r_wr_ptr + w_off[i]] <= in_data_i[REC_W*i +: REC_W];
                r_mem_port[r_wr_ptr + w_off[i]] <= PORT_W'(i);
            end
        end
    end

    assign out_valid_o = (r_count != '0);
    assign out_data_o  = r_mem_data[r_rd_ptr];
    assign out_port_o  = r_mem_port[r_rd_ptr];
    assign count_o     = r_count;
    assign drop_cnt_o  = r_drop_cnt;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_cva6_trace_buffer.sv
// Testbench for cva6_trace_buffer (NR_PORTS=2, REC_W=8, DEPTH=4, CNT_W=4).
// A hand-written table checks occupancy and drop state. A queue scoreboard
// checks the head record after every cycle.
module tb_cva6_trace_buffer;

    localparam int NR_PORTS = 2;
    localparam int REC_W    = 8;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = 15;

    logic                      clk;
    logic                      rstN;
    logic                      enable;
    logic [NR_PORTS-1:0]       inValid;
    logic [NR_PORTS*REC_W-1:0] inData;
    logic                      outValid;
    logic                      outReady;
    logic [REC_W-1:0]          outData;
    logic                      outPort;
    logic [2:0]                countOut;
    logic [CNT_W-1:0]          dropCnt;
    logic                      overflow;
    logic                      clear;

    typedef struct packed {
        logic       en;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ready;
        logic       clr;
        logic [2:0] expCount;
        logic [3:0] expDrop;
        logic       expOvf;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       port;
    } rec_t;

    rec_t sbQueue[$];
    vec_t vecs[13];
    int   errors = 0;
    int   checks = 0;
    int   modelDrop = 0;
    bit   modelOvf = 1'b0;

    cva6_trace_buffer #(
        .NR_PORTS(NR_PORTS),
        .REC_W   (REC_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .enable_i   (enable),
        .in_valid_i (inValid),
        .in_data_i  (inData),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .out_data_o (outData),
        .out_port_o (outPort),
        .count_o    (countOut),
        .drop_cnt_o (dropCnt),
        .overflow_o (overflow),
        .clear_i    (clear)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and step the reference model. The inputs are
    // driven at a negedge. The routine returns at the following negedge.
    task automatic applyStimulus(input logic en, input logic [1:0] valid,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic ready, input logic clr);
        int k;
        int space;
        bit deq;
        enable   = en;
        inValid  = valid;
        inData   = {d1, d0};
        outReady = ready;
        clear    = clr;
        k        = en ? (int'(valid[0]) + int'(valid[1])) : 0;
        deq      = (sbQueue.size() != 0) && ready;
        space    = DEPTH - sbQueue.size() + int'(deq);
        if (deq) void'(sbQueue.pop_front());
        if (k > 0 && k <= space) begin
            if (valid[0]) sbQueue.push_back('{d0, 1'b0});
            if (valid[1]) sbQueue.push_back('{d1, 1'b1});
        end
        if (clr) begin
            modelDrop = 0;
            modelOvf  = 1'b0;
        end else if (k > space) begin
            modelDrop = (modelDrop + k > CNT_MAX) ? CNT_MAX : modelDrop + k;
            modelOvf  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare the outputs with the scoreboard head and the model state.
    task automatic checkOutput(input string tag);
        check({tag, ".valid"}, 32'(outValid), 32'(sbQueue.size() != 0));
        if (sbQueue.size() != 0) begin
            check({tag, ".data"}, 32'(outData), 32'(sbQueue[0].data));
            check({tag, ".port"}, 32'(outPort), 32'(sbQueue[0].port));
        end
        check({tag, ".count"}, 32'(countOut), 32'(sbQueue.size()));
        check({tag, ".drop"}, 32'(dropCnt), 32'(modelDrop));
        check({tag, ".ovf"}, 32'(overflow), 32'(modelOvf));
    endtask

    // Main test sequence.
    initial begin
        rstN     = 1'b0;
        enable   = 1'b0;
        inValid  = '0;
        inData   = '0;
        outReady = 1'b0;
        clear    = 1'b0;

        //          en    valid  d0     d1     rdy   clr   cnt   drop  ovf
        vecs[0]  = '{1'b1, 2'b11, 8'hA0, 8'hB1, 1'b1, 1'b0, 3'd2, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 2'b11, 8'h10, 8'h11, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0};
        vecs[4]  = '{1'b1, 2'b11, 8'h20, 8'h21, 1'b0, 1'b0, 3'd4, 4'd0, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 8'h30, 8'h00, 1'b0, 1'b0, 3'd4, 4'd1, 1'b1};
        vecs[6]  = '{1'b1, 2'b01, 8'h40, 8'h00, 1'b1, 1'b0, 3'd4, 4'd1, 1'b1};
        vecs[7]  = '{1'b1, 2'b11, 8'h50, 8'h51, 1'b1, 1'b0, 3'd3, 4'd3, 1'b1};
        vecs[8]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 4'd3, 1'b1};
        vecs[9]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 4'd3, 1'b1};
        vecs[10] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 4'd3, 1'b1};
        vecs[11] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 4'd3, 1'b1};
        vecs[12] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0};

        repeat (2) @(negedge clk);
        check("rst.valid", 32'(outValid), 32'd0);
        check("rst.count", 32'(countOut), 32'd0);
        check("rst.drop", 32'(dropCnt), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("idle");

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].d0, vecs[i].d1,
                          vecs[i].ready, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tcount", i), 32'(countOut), 32'(vecs[i].expCount));
            check($sformatf("vec%0d.tdrop", i), 32'(dropCnt), 32'(vecs[i].expDrop));
            check($sformatf("vec%0d.tovf", i), 32'(overflow), 32'(vecs[i].expOvf));
        end

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 2'b01, 8'(i + 8'h60), 8'h00, 1'b1, 1'b0);
            checkOutput($sformatf("wrap%0d", i));
        end
        repeat (2) begin
            applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
            checkOutput("wrapDrain");
        end
        check("wrap.noDrop", 32'(dropCnt), 32'd0);
        check("wrap.empty", 32'(outValid), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 2'b11, 8'(8'h80 + 2 * i), 8'(8'h81 + 2 * i), 1'b0, 1'b0);
            checkOutput($sformatf("sat%0d", i));
        end
        check("sat.drop", 32'(dropCnt), 32'd15);
        check("sat.ovf", 32'(overflow), 32'd1);
        check("sat.count", 32'(countOut), 32'd4);

        applyStimulus(1'b1, 2'b11, 8'hC0, 8'hC1, 1'b0, 1'b1);
        checkOutput("clear");
        check("clear.drop", 32'(dropCnt), 32'd0);
        check("clear.ovf", 32'(overflow), 32'd0);

        applyStimulus(1'b0, 2'b11, 8'hD0, 8'hD1, 1'b0, 1'b0);
        checkOutput("disabled");
        check("disabled.count", 32'(countOut), 32'd4);
        check("disabled.drop", 32'(dropCnt), 32'd0);

        repeat (4) begin
            applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
            checkOutput("drain");
        end
        applyStimulus(1'b1, 2'b11, 8'hE0, 8'hE1, 1'b0, 1'b0);
        checkOutput("refill0");
        applyStimulus(1'b1, 2'b01, 8'hE2, 8'h00, 1'b0, 1'b0);
        checkOutput("refill1");
        check("refill.count", 32'(countOut), 32'd3);

        #2 rstN = 1'b0;
        #1;
        check("midRst.count", 32'(countOut), 32'd0);
        check("midRst.valid", 32'(outValid), 32'd0);
        sbQueue.delete();
        modelDrop = 0;
        modelOvf  = 1'b0;
        @(negedge clk);
        rstN    = 1'b1;
        inValid = '0;
        @(negedge clk);
        checkOutput("postRst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
